// File: rtl/delay_event_sched_pkg.sv
// delay_event_sched_pkg: shared widths, queue entry type and delay clamp helper.
package delay_event_sched_pkg;
  localparam int SCHED_TIME_W = 64;
  localparam int SCHED_DLY_W  = 16;
  typedef struct packed {
    logic                    valid;
    logic [SCHED_TIME_W-1:0] deadline;
  } sched_entry_t;
  // A zero delay would collide with the push edge itself, so it is promoted to one tick.
  function automatic logic [SCHED_DLY_W-1:0] clamp_dly(input logic [SCHED_DLY_W-1:0] d);
    return (d == '0) ? SCHED_DLY_W'(1) : d;
  endfunction
endpackage

// File: rtl/dly_sort_queue.sv
// dly_sort_queue: deadline-sorted register queue with single insert and head pop.
//   clk, rst_n         clock, async active-low reset
//   push, push_deadline insert request (dropped when full and not popping)
//   pop                remove head this edge (evaluated on the pre-push contents)
//   head, head_valid   earliest entry
//   count              number of valid entries
module dly_sort_queue
  import delay_event_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [SCHED_TIME_W-1:0] push_deadline,
  input  logic                    pop,
  output sched_entry_t            head,
  output logic                    head_valid,
  output logic [CNT_W-1:0]        count
);
  sched_entry_t     ent_q [DEPTH];
  sched_entry_t     ent_d [DEPTH];
  sched_entry_t     post  [DEPTH];
  sched_entry_t     new_ent;
  logic [DEPTH-1:0] le;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop, do_push;
  always_comb begin
    do_pop  = pop && ent_q[0].valid;
    do_push = push && (do_pop || count_q != CNT_W'(DEPTH));
    new_ent = '{valid: 1'b1, deadline: push_deadline};
    for (int i = 0; i < DEPTH; i++) post[i] = ent_q[i];
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) post[i] = ent_q[i+1];
      post[DEPTH-1] = '0;
    end
    // le is a run of ones then zeros: entries that stay ahead of the new one (ties stay ahead).
    for (int i = 0; i < DEPTH; i++) le[i] = post[i].valid && post[i].deadline <= push_deadline;
    ent_d[0] = (do_push && !le[0]) ? new_ent : post[0];
    for (int i = 1; i < DEPTH; i++)
      ent_d[i] = (do_push && !le[i]) ? (le[i-1] ? new_ent : post[i-1]) : post[i];
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end
  assign head       = ent_q[0];
  assign head_valid = ent_q[0].valid;
  assign count      = count_q;
endmodule

// File: rtl/delay_event_sched.sv
// delay_event_sched: fires delayed events on a tick time base in deadline order.
//   clk, rst_n   one edge per tick, async active-low reset
//   trig, dly    rising edge of trig schedules a fire at now + max(dly,1)
//   clr          sync clear of out, late, ovf (a same-edge fire wins)
//   now          free-running tick counter
//   fire, stamp  one-cycle fire pulse and deadline of the last fired event
//   out, late, ovf sticky flags; pending = queued events
module delay_event_sched
  import delay_event_sched_pkg::*;
#(
  parameter int TIME_W = SCHED_TIME_W,
  parameter int DLY_W  = SCHED_DLY_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [DLY_W-1:0]  dly,
  input  logic              clr,
  output logic [TIME_W-1:0] now,
  output logic              fire,
  output logic              out,
  output logic [TIME_W-1:0] stamp,
  output logic              late,
  output logic              ovf,
  output logic [CNT_W-1:0]  pending
);
  sched_entry_t      head;
  logic              head_valid, push, pop;
  logic [TIME_W-1:0] push_deadline;
  logic [TIME_W-1:0] now_q, now_d, stamp_q, stamp_d;
  logic              trig_q, trig_d, fire_q, fire_d, out_q, out_d, late_q, late_d, ovf_q, ovf_d;
  dly_sort_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .push_deadline (push_deadline),
    .pop           (pop),
    .head          (head),
    .head_valid    (head_valid),
    .count         (pending)
  );
  always_comb begin
    push          = trig && !trig_q;
    pop           = head_valid && now_q >= head.deadline;
    push_deadline = now_q + TIME_W'(clamp_dly(dly));
    now_d         = now_q + TIME_W'(1);
    trig_d        = trig;
    fire_d        = pop;
    stamp_d       = pop ? head.deadline : stamp_q;
    out_d         = pop || (out_q && !clr);
    late_d        = (pop && now_q > head.deadline) || (late_q && !clr);
    // A pop frees a slot on the same edge, so only a no-pop push into a full queue is dropped.
    ovf_d         = (push && !pop && pending == CNT_W'(DEPTH)) || (ovf_q && !clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q   <= '0;
      stamp_q <= '0;
      trig_q  <= 1'b0;
      fire_q  <= 1'b0;
      out_q   <= 1'b0;
      late_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      now_q   <= now_d;
      stamp_q <= stamp_d;
      trig_q  <= trig_d;
      fire_q  <= fire_d;
      out_q   <= out_d;
      late_q  <= late_d;
      ovf_q   <= ovf_d;
    end
  end
  assign now   = now_q;
  assign fire  = fire_q;
  assign out   = out_q;
  assign stamp = stamp_q;
  assign late  = late_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_delay_event_sched.sv
// tb_delay_event_sched: directed table, reset corner case and random run against a queue model.
module tb_delay_event_sched;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] dly = '0;
  logic        clr = 1'b0;
  logic [63:0] now, stamp;
  logic        fire, out, late, ovf;
  logic [2:0]  pending;
  int errors = 0;
  int checks = 0;
  longint unsigned mnow, mstamp;
  bit mfire, mout, mlate, movf, mtrig;
  longint unsigned mq[$];
  typedef struct {
    bit rst; int at; bit trig; int dly; bit clr;
    bit fire; bit out; bit late; bit ovf; longint unsigned stamp; int pend;
  } vec_t;
  vec_t tbl[$];

  delay_event_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .dly(dly), .clr(clr),
    .now(now), .fire(fire), .out(out), .stamp(stamp), .late(late), .ovf(ovf), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    mnow = 0; mstamp = 0; mfire = 0; mout = 0; mlate = 0; movf = 0; mtrig = 0;
    mq.delete();
  endfunction

  function automatic void model_step(input bit t, input int d, input bit c);
    bit p, pu;
    longint unsigned dl;
    int idx;
    p  = mq.size() > 0 && mnow >= mq[0];
    pu = t && !mtrig;
    mfire = p;
    mout  = p ? 1'b1 : (c ? 1'b0 : mout);
    mlate = (p && mnow > mq[0]) ? 1'b1 : (c ? 1'b0 : mlate);
    movf  = (pu && !p && mq.size() == DEPTH) ? 1'b1 : (c ? 1'b0 : movf);
    if (p) begin
      mstamp = mq[0];
      void'(mq.pop_front());
    end
    if (pu && mq.size() < DEPTH) begin
      dl  = mnow + longint'((d == 0) ? 1 : d);
      idx = 0;
      while (idx < mq.size() && mq[idx] <= dl) idx++;
      mq.insert(idx, dl);
    end
    mnow++;
    mtrig = t;
  endfunction

  task automatic cmp_model();
    chk("now", now, mnow);
    chk("fire", 64'(fire), 64'(mfire));
    chk("out", 64'(out), 64'(mout));
    chk("stamp", stamp, mstamp);
    chk("late", 64'(late), 64'(mlate));
    chk("ovf", 64'(ovf), 64'(movf));
    chk("pending", 64'(pending), 64'(mq.size()));
  endtask

  task automatic step(input bit t, input int d, input bit c);
    trig = t; dly = 16'(d); clr = c;
    @(posedge clk);
    model_step(t, d, c);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    trig = 0; dly = '0; clr = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic void add(input bit r, input int a, input bit t, input int d, input bit c,
                              input bit f, input bit o, input bit l, input bit v,
                              input longint unsigned s, input int p);
    vec_t x;
    x = '{r, a, t, d, c, f, o, l, v, s, p};
    tbl.push_back(x);
  endfunction

  initial begin
    // basic latency
    add(1, 10, 1, 24, 0, 0, 0, 0, 0, 0, 1);
    add(0, 34, 0, 0, 0, 1, 1, 0, 0, 34, 0);
    add(0, 35, 0, 0, 0, 0, 1, 0, 0, 34, 0);
    // reordering
    add(1, 10, 1, 26, 0, 0, 0, 0, 0, 0, 1);
    add(0, 12, 1, 20, 0, 0, 0, 0, 0, 0, 2);
    add(0, 32, 0, 0, 0, 1, 1, 0, 0, 32, 1);
    add(0, 33, 0, 0, 0, 0, 1, 0, 0, 32, 1);
    add(0, 36, 0, 0, 0, 1, 1, 0, 0, 36, 0);
    // ties, dly=0, clr
    add(1, 10, 1, 30, 0, 0, 0, 0, 0, 0, 1);
    add(0, 12, 1, 28, 0, 0, 0, 0, 0, 0, 2);
    add(0, 40, 0, 0, 0, 1, 1, 0, 0, 40, 1);
    add(0, 41, 0, 0, 0, 1, 1, 1, 0, 40, 0);
    add(0, 42, 0, 0, 0, 0, 1, 1, 0, 40, 0);
    add(0, 50, 1, 0, 0, 0, 1, 1, 0, 40, 1);
    add(0, 51, 0, 0, 0, 1, 1, 1, 0, 51, 0);
    add(0, 52, 0, 0, 1, 0, 0, 0, 0, 51, 0);
    // overflow
    add(1, 2, 1, 100, 0, 0, 0, 0, 0, 0, 1);
    add(0, 4, 1, 100, 0, 0, 0, 0, 0, 0, 2);
    add(0, 6, 1, 100, 0, 0, 0, 0, 0, 0, 3);
    add(0, 8, 1, 100, 0, 0, 0, 0, 0, 0, 4);
    add(0, 10, 1, 100, 0, 0, 0, 0, 1, 0, 4);
    add(0, 102, 0, 0, 0, 1, 1, 0, 1, 102, 3);
    add(0, 104, 0, 0, 0, 1, 1, 0, 1, 104, 2);
    add(0, 106, 0, 0, 0, 1, 1, 0, 1, 106, 1);
    add(0, 108, 0, 0, 0, 1, 1, 0, 1, 108, 0);
    add(0, 200, 0, 0, 0, 0, 1, 0, 1, 108, 0);
    // full with simultaneous pop, then clr on a fire edge
    add(1, 2, 1, 48, 0, 0, 0, 0, 0, 0, 1);
    add(0, 4, 1, 60, 0, 0, 0, 0, 0, 0, 2);
    add(0, 6, 1, 60, 0, 0, 0, 0, 0, 0, 3);
    add(0, 8, 1, 60, 0, 0, 0, 0, 0, 0, 4);
    add(0, 50, 1, 10, 0, 1, 1, 0, 0, 50, 4);
    add(0, 60, 0, 0, 0, 1, 1, 0, 0, 60, 3);
    add(0, 64, 0, 0, 1, 1, 1, 0, 0, 64, 2);

    do_reset();
    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      while (mnow < longint'(tbl[k].at)) step(0, 0, 0);
      step(tbl[k].trig, tbl[k].dly, tbl[k].clr);
      chk($sformatf("tbl%0d.now", k), now, 64'(tbl[k].at + 1));
      chk($sformatf("tbl%0d.fire", k), 64'(fire), 64'(tbl[k].fire));
      chk($sformatf("tbl%0d.out", k), 64'(out), 64'(tbl[k].out));
      chk($sformatf("tbl%0d.late", k), 64'(late), 64'(tbl[k].late));
      chk($sformatf("tbl%0d.ovf", k), 64'(ovf), 64'(tbl[k].ovf));
      chk($sformatf("tbl%0d.stamp", k), stamp, tbl[k].stamp);
      chk($sformatf("tbl%0d.pending", k), 64'(pending), 64'(tbl[k].pend));
    end

    // reset mid-operation discards pending events
    do_reset();
    for (int i = 0; i < 6; i++) step(i % 2 == 0, 30, 0);
    while (mnow < 20) step(0, 0, 0);
    chk("rst_pre_pending", 64'(pending), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_now", now, 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_flags", {60'd0, fire, out, late, ovf}, 64'd0);
    chk("rst_stamp", stamp, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0);
      chk("no_fire_after_rst", 64'(fire), 64'd0);
    end

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 24)), ($urandom % 32) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
